// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU; op 1001 is an iterative multiply only when ALU_SEQ_MUL_EN is defined.
// Latency: 1 cycle for single-cycle ops, n cycles for shifts by n > 0, WIDTH cycles for mul.
// Backpressure: one op in flight; result held in DONE until out_ready, in_ready only in IDLE.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_SAR = 4'h8;
    localparam logic [3:0] OP_MUL = 4'h9;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           r_state;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_w;
    logic [SW-1:0]    r_cnt;

    // Returns {bit shifted out, shifted value} for a single-bit shift.
    function automatic logic [WIDTH:0] shift1(input logic [3:0] f_op, input logic [WIDTH-1:0] f_v);
        case (f_op)
            OP_SHL:  shift1 = {f_v[WIDTH-1], f_v[WIDTH-2:0], 1'b0};
            OP_SAR:  shift1 = {f_v[0], f_v[WIDTH-1], f_v[WIDTH-1:1]};
            default: shift1 = {f_v[0], 1'b0, f_v[WIDTH-1:1]};
        endcase
    endfunction

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_sh1;
    logic [WIDTH:0]   w_step;
    logic [SW-1:0]    w_n;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_err;
    logic             w_iter;
    logic [WIDTH-1:0] w_fin_res;
    logic             w_fin_c;

    assign w_sum    = {1'b0, a} + {1'b0, b};
    assign w_diff   = {1'b0, a} - {1'b0, b};
    assign w_sh1    = shift1(op, a);
    assign w_step   = shift1(r_op, r_w);
    assign w_n      = b[SW-1:0];
    assign in_ready = rst_n && (r_state == IDLE);

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] w_acc_nxt;

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif

    always_comb begin
        w_res  = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        w_err  = 1'b0;
        w_iter = 1'b0;
        case (op)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_NOT: w_res = ~a;
            OP_SHL, OP_SHR, OP_SAR: begin
                // n = 1 finishes at accept, so latency stays n for every shift.
                if (w_n == '0) begin
                    w_res = a;
                end else if (w_n == SW'(1)) begin
                    w_res = w_sh1[WIDTH-1:0];
                    w_c   = w_sh1[WIDTH];
                end else begin
                    w_iter = 1'b1;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL:  w_iter = 1'b1;
`endif
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_fin_res = w_step[WIDTH-1:0];
        w_fin_c   = w_step[WIDTH];
`ifdef ALU_SEQ_MUL_EN
        if (r_op == OP_MUL) begin
            w_fin_res = w_acc_nxt[WIDTH-1:0];
            w_fin_c   = |w_acc_nxt[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        r_op <= op;
                        if (w_iter) begin
                            // First step happens at accept; BUSY covers the remaining steps.
                            r_state <= BUSY;
                            r_w     <= w_sh1[WIDTH-1:0];
                            r_cnt   <= w_n - SW'(1);
`ifdef ALU_SEQ_MUL_EN
                            if (op == OP_MUL) begin
                                r_acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
                                r_mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
                                r_mplier <= {1'b0, b[WIDTH-1:1]};
                                r_cnt    <= SW'(WIDTH-1);
                            end
`endif
                        end else begin
                            r_state   <= DONE;
                            out_valid <= 1'b1;
                            result    <= w_res;
                            flags     <= w_err ? 4'b0000 : {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
                            err       <= w_err;
                        end
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt - SW'(1);
                    r_w   <= w_step[WIDTH-1:0];
`ifdef ALU_SEQ_MUL_EN
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
`endif
                    if (r_cnt == SW'(1)) begin
                        r_state   <= DONE;
                        out_valid <= 1'b1;
                        result    <= w_fin_res;
                        flags     <= {w_fin_res[WIDTH-1], (w_fin_res == '0), w_fin_c, 1'b0};
                        err       <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state   <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
